pipeline_stall_ctrl: RTL
========================

Name: pipeline_stall_ctrl

Overview:
- Consumer side of the dual-issue hazard interface: takes ld_has_hazard / jr_has_hazard from the ID-stage hazard unit, the EX-stage flush request and the data-memory busy flag.
- Drives the pipeline-register enables, flushes and bubbles for both issue lanes.
- Sequences multi-cycle load stalls and jr wrong-path kills with a small FSM.
- Keeps saturating stall/flush performance counters.

Parameters:
- LD_STALL_CYCLES, 1, bubble cycles inserted per load-use hazard (>=1).
- JR_PENALTY, 2, total cycles of IF/ID kill per jr (>=1).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ld_has_hazard  in  1  load-use hazard on either lane in ID.
- jr_has_hazard  in  1  jr in ID with no load hazard.
- flush_req  in  1  EX branch redirect; squash younger instructions.
- mem_busy  in  1  data memory not ready; freeze whole pipeline.
- cnt_clr  in  1  synchronous clear of both perf counters.
- pc_en  out  1  PC register write enable.
- pc_sel_jr  out  1  select jr target into PC.
- ifid_en  out  1  IF/ID write enable.
- ifid_flush  out  1  load NOP into IF/ID (both lanes).
- idex_bubble1  out  1  load NOP into ID/EX lane 1.
- idex_bubble2  out  1  load NOP into ID/EX lane 2.
- pipe_en  out  1  enable for ID/EX, EX/MEM and MEM/WB.
- stall_cnt  out  CNT_W  load-stall cycles counted.
- flush_cnt  out  CNT_W  flush_req events counted.
- state  out  2  current FSM state (debug).

Behaviour:
- States: RUN=0, LD_STALL=1, JR_KILL=2; 3 is illegal and returns to RUN. Internal down-counter cnt holds the remaining cycles.
- Outputs are Mealy (same-cycle) functions of state and inputs. Unless stated otherwise: pc_en=1, ifid_en=1, pipe_en=1, all others 0.
- While rst=1: state=RUN, cnt=0, both counters=0; pc_en, ifid_en and pipe_en forced 0; all other outputs 0.
- Per-cycle priority: mem_busy > flush_req > ld_has_hazard > jr_has_hazard.
- mem_busy, any state: pc_en=ifid_en=pipe_en=0, no flush or bubble; state, cnt and counters hold.
- flush_req, any state (not busy):
  - ifid_flush=1, idex_bubble1=idex_bubble2=1, pc_en=1.
  - Next state RUN, cnt=0, flush_cnt+1.
  - Aborts any pending stall or kill.
- RUN + ld_has_hazard:
  - pc_en=0, ifid_en=0, both bubbles=1, stall_cnt+1.
  - If LD_STALL_CYCLES>1: go LD_STALL, cnt=LD_STALL_CYCLES-1. Otherwise stay in RUN.
- RUN + jr_has_hazard:
  - pc_sel_jr=1, pc_en=1, ifid_flush=1 (squash wrong-path fetch).
  - If JR_PENALTY>1: go JR_KILL, cnt=JR_PENALTY-1.
- LD_STALL:
  - Same outputs as the RUN load-stall cycle; stall_cnt+1; ld_has_hazard and jr_has_hazard ignored.
  - cnt decrements; when cnt==1, next state is RUN.
- JR_KILL:
  - pc_en=0, ifid_flush=1, no bubbles.
  - cnt decrements; when cnt==1, next state is RUN; hazard inputs ignored.
- Counters saturate at all-ones. cnt_clr wins over a same-cycle increment. cnt_clr is honoured even during mem_busy.
- Reset asserted mid-operation: immediate return to RUN with all state cleared; no residual stall after release.

Decomposition:
- Shared package pipe_ctrl_pkg holds the state localparams (ST_RUN, ST_LD_STALL, ST_JR_KILL) and the default CNT_W.
- One sub-module, sat_counter (CNT_W wide; inc, clr, saturate), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Default parameters, 1-cycle ld_has_hazard in RUN -> exactly 1 cycle of pc_en=0, ifid_en=0, idex_bubble1=idex_bubble2=1; state stays 0; stall_cnt=1.
- jr_has_hazard for 1 cycle, JR_PENALTY=2:
  - cycle0: pc_sel_jr=1, pc_en=1, ifid_flush=1, state->2.
  - cycle1: pc_en=0, ifid_flush=1, state->0.
  - cycle2: all defaults.
- flush_req and ld_has_hazard asserted together -> ifid_flush=1, bubbles=1, pc_en=1; flush_cnt=1, stall_cnt=0.
- LD_STALL_CYCLES=3, load hazard, then mem_busy for 2 cycles during LD_STALL:
  - cnt holds during busy; stall lasts 3 non-busy cycles total; stall_cnt=3.
  - pipe_en=0 only during the busy cycles.
- rst pulsed while in JR_KILL with counters non-zero -> state=0, stall_cnt=flush_cnt=0; after release, pc_en=1 and no flush.
- CNT_W=4, 20 consecutive load-stall cycles -> stall_cnt sticks at 15; cnt_clr together with a stall -> stall_cnt=0 next cycle.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall controller: FSM state encoding,
// default perf-counter width and a helper sizing the internal cycle counter.
package pipe_ctrl_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LD_STALL = 2'd1,
    ST_JR_KILL  = 2'd2,
    ST_BAD      = 2'd3
  } state_e;

  // Bits needed to hold the larger of two cycle budgets.
  function automatic int cyc_bits(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Ports: clk, rst (async high), inc_i, clr_i -> cnt_o.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Dual-issue stall/flush controller: turns hazard, flush and mem-busy
// inputs into PC/IF-ID/ID-EX enables, flushes and bubbles (Mealy), runs
// a RUN/LD_STALL/JR_KILL FSM and keeps saturating stall/flush counters.
// Inputs: clk, rst, ld_has_hazard, jr_has_hazard, flush_req, mem_busy,
// cnt_clr. Outputs: pc_en, pc_sel_jr, ifid_en, ifid_flush, idex_bubble1/2,
// pipe_en, stall_cnt, flush_cnt, state.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LD_STALL_CYCLES = 1,
  parameter int JR_PENALTY      = 2,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_has_hazard,
  input  logic             jr_has_hazard,
  input  logic             flush_req,
  input  logic             mem_busy,
  input  logic             cnt_clr,
  output logic             pc_en,
  output logic             pc_sel_jr,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble1,
  output logic             idex_bubble2,
  output logic             pipe_en,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state
);

  localparam int CW = cyc_bits(LD_STALL_CYCLES, JR_PENALTY);

  state_e          st_q, st_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            stall_inc;
  logic            flush_inc;

  always_comb begin
    st_d         = st_q;
    cnt_d        = cnt_q;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    pc_en        = 1'b1;
    pc_sel_jr    = 1'b0;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble1 = 1'b0;
    idex_bubble2 = 1'b0;
    pipe_en      = 1'b1;

    if (mem_busy) begin
      // Whole pipe frozen; FSM and counters hold.
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      pipe_en = 1'b0;
    end else if (flush_req) begin
      // Redirect wins over any pending stall or kill.
      ifid_flush   = 1'b1;
      idex_bubble1 = 1'b1;
      idex_bubble2 = 1'b1;
      st_d         = ST_RUN;
      cnt_d        = '0;
      flush_inc    = 1'b1;
    end else begin
      unique case (st_q)
        ST_RUN: begin
          if (ld_has_hazard) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_bubble1 = 1'b1;
            idex_bubble2 = 1'b1;
            stall_inc    = 1'b1;
            if (LD_STALL_CYCLES > 1) begin
              st_d  = ST_LD_STALL;
              cnt_d = CW'(LD_STALL_CYCLES - 1);
            end
          end else if (jr_has_hazard) begin
            pc_sel_jr  = 1'b1;
            ifid_flush = 1'b1;
            if (JR_PENALTY > 1) begin
              st_d  = ST_JR_KILL;
              cnt_d = CW'(JR_PENALTY - 1);
            end
          end
        end
        ST_LD_STALL: begin
          pc_en        = 1'b0;
          ifid_en      = 1'b0;
          idex_bubble1 = 1'b1;
          idex_bubble2 = 1'b1;
          stall_inc    = 1'b1;
          cnt_d        = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            st_d = ST_RUN;
          end
        end
        ST_JR_KILL: begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
          cnt_d      = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            st_d = ST_RUN;
          end
        end
        default: begin
          st_d  = ST_RUN;
          cnt_d = '0;
        end
      endcase
    end

    // Reset is level-sensitive on the outputs too, not only on the flops.
    if (rst) begin
      pc_en        = 1'b0;
      pc_sel_jr    = 1'b0;
      ifid_en      = 1'b0;
      ifid_flush   = 1'b0;
      idex_bubble1 = 1'b0;
      idex_bubble2 = 1'b0;
      pipe_en      = 1'b0;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= ST_RUN;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  assign state = st_q;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc_i(stall_inc),
    .clr_i(cnt_clr),
    .cnt_o(stall_cnt)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc_i(flush_inc),
    .clr_i(cnt_clr),
    .cnt_o(flush_cnt)
  );

endmodule
